inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Boot-time program loader upstream of the single-cycle MIPS core. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words sequentially into instruction memory through a dedicated write port. It holds the core in reset until a complete, checksum-verified image has been loaded.

Parameters:
ADDR_WIDTH, 8, word-index width; maximum image size is 2^ADDR_WIDTH words
BASE_ADDR, 32'h00000000, byte address of the first instruction word written

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load (accepted in IDLE, DONE, ERROR)
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction-memory write enable, one cycle per word
mem_addr  output  32  byte address of the write (BASE_ADDR + 4*index)
mem_wdata  output  32  assembled instruction word
cpu_reset  output  1  hold-reset to the core; low only in DONE
done  output  1  image loaded and verified
error  output  1  load aborted (oversize or checksum mismatch)
words_loaded  output  ADDR_WIDTH+1  count of words written in the current load

Behaviour:
- Frame format: LEN_HI, LEN_LO (word count N, 16-bit big-endian), then 4*N data bytes (MSB first per word), then CHK. CHK is the XOR of every preceding byte in the frame.
- Byte transfer occurs on a rising edge with byte_valid & byte_ready. byte_in is ignored otherwise. Source may stall arbitrarily.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE, ERROR.
- Reset (async): state=IDLE; cpu_reset=1; byte_ready=0; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; done=0; error=0; words_loaded=0; internal count, shift register and XOR accumulator cleared.
- IDLE: byte_ready=0. On start, go to HDR_HI and clear the accumulator, words_loaded and byte counter.
- HDR_HI/HDR_LO: byte_ready=1. Capture length bytes and XOR them into the accumulator.
  - After LEN_LO: if N > 2^ADDR_WIDTH, go to ERROR.
  - Else if N=0, go to CHECK.
  - Else go to DATA.
- DATA: byte_ready=1. Shift each byte into the word register (first byte lands in [31:24]) and XOR it into the accumulator. On the 4th byte go to WRITE.
- WRITE: exactly one cycle. byte_ready=0, mem_we=1, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*words_loaded (32-bit wrap).
  - words_loaded increments at the end of the cycle.
  - If the new count equals N, go to CHECK; else go to DATA.
- Latency: 4th data byte accepted at edge k → mem_we high for the cycle after edge k, deasserted after edge k+1.
- Throughput: at most 1 word per 5 cycles.
- CHECK: byte_ready=1. On CHK acceptance: if CHK equals the accumulator, go to DONE; else go to ERROR. No further bytes are accepted after CHK.
- DONE: done=1, cpu_reset=0, byte_ready=0. Holds until start or reset.
- ERROR: error=1, cpu_reset=1, byte_ready=0. Holds until start or reset.
- start in DONE/ERROR: cpu_reset=1 from the next cycle, done/error clear, and the FSM goes to HDR_HI (reload).
- start is ignored in HDR_HI..CHECK.
- Already-written words are not invalidated on ERROR; cpu_reset stays high, so they are never executed.
- mem_we is never high outside WRITE. All outputs are registered.
- Reset asserted mid-load aborts immediately: no partial write completes, and the next load requires a fresh start.

Test Plan:
- Nominal load: N=2, stream 00,02,8C,01,00,04,00,22,18,20,91 with no stalls → two mem_we pulses: (0x00000000, 0x8C010004), (0x00000004, 0x00221820). Then done=1, cpu_reset=0, words_loaded=2.
- Stalled source: same frame with byte_valid low for 3 cycles between every byte → identical writes and final state. No byte is accepted while byte_ready=0 in WRITE.
- Bad checksum: same frame with CHK=0x90 → both writes occur, then error=1, done=0, cpu_reset=1. A following start followed by the correct frame → done=1.
- Oversize: ADDR_WIDTH=8, header 01,01 → ERROR right after LEN_LO. No mem_we pulses, byte_ready=0. N=0x0100 instead is accepted.
- Empty image: 00,00,00 → no writes, done=1, words_loaded=0. With CHK=0x01 instead → error=1.
- Reset mid-word: assert reset after the 2nd data byte of word 0 → all outputs at reset values asynchronously. No mem_we. Bytes presented without start are not accepted.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time program loader: parses a framed big-endian byte stream, writes 32-bit
// instruction words into instruction memory and releases the core once the image checksum verifies.
module inst_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  logic [2:0]          r_state;
  logic [15:0]         r_len;
  logic [7:0]          r_acc;
  logic [1:0]          r_cnt;
  logic [23:0]         r_word;
  logic [ADDR_WIDTH:0] r_wl;
  logic                r_byte_ready;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_reset;
  logic                r_done;
  logic                r_error;

  logic [2:0]          w_state_next;
  logic [15:0]         w_len_next;
  logic [7:0]          w_acc_next;
  logic [1:0]          w_cnt_next;
  logic [23:0]         w_word_next;
  logic [ADDR_WIDTH:0] w_wl_next;
  logic                w_we_next;
  logic [31:0]         w_addr_next;
  logic [31:0]         w_wdata_next;

  logic                w_xfer;
  logic [15:0]         w_len_new;
  logic [ADDR_WIDTH:0] w_wl_inc;

  assign w_xfer    = byte_valid & r_byte_ready;
  assign w_len_new = {r_len[15:8], byte_in};
  assign w_wl_inc  = r_wl + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_word_next  = r_word;
    w_wl_next    = r_wl;
    w_we_next    = 1'b0;
    w_addr_next  = r_mem_addr;
    w_wdata_next = r_mem_wdata;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_next = S_HDR_HI;
          w_acc_next   = 8'h00;
          w_wl_next    = '0;
          w_cnt_next   = 2'd0;
        end
      end

      S_HDR_HI: begin
        if (w_xfer) begin
          w_len_next   = {byte_in, r_len[7:0]};
          w_acc_next   = r_acc ^ byte_in;
          w_state_next = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        if (w_xfer) begin
          w_len_next = w_len_new;
          w_acc_next = r_acc ^ byte_in;
          if ({16'd0, w_len_new} > MAX_WORDS)
            w_state_next = S_ERROR;
          else if (w_len_new == 16'd0)
            w_state_next = S_CHECK;
          else
            w_state_next = S_DATA;
        end
      end

      S_DATA: begin
        if (w_xfer) begin
          w_word_next = {r_word[15:0], byte_in};
          w_acc_next  = r_acc ^ byte_in;
          w_cnt_next  = r_cnt + 2'd1;
          // Fourth byte completes the word: present it on the write port next cycle.
          if (r_cnt == 2'd3) begin
            w_state_next = S_WRITE;
            w_we_next    = 1'b1;
            w_wdata_next = {r_word, byte_in};
            w_addr_next  = BASE_ADDR + (32'(r_wl) << 2);
          end
        end
      end

      S_WRITE: begin
        w_wl_next = w_wl_inc;
        if (32'(w_wl_inc) == {16'd0, r_len})
          w_state_next = S_CHECK;
        else
          w_state_next = S_DATA;
      end

      S_CHECK: begin
        if (w_xfer)
          w_state_next = (byte_in == r_acc) ? S_DONE : S_ERROR;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs are derived from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= 16'd0;
      r_acc        <= 8'h00;
      r_cnt        <= 2'd0;
      r_word       <= 24'd0;
      r_wl         <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_mem_wdata  <= 32'd0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_len        <= w_len_next;
      r_acc        <= w_acc_next;
      r_cnt        <= w_cnt_next;
      r_word       <= w_word_next;
      r_wl         <= w_wl_next;
      r_byte_ready <= (w_state_next == S_HDR_HI) || (w_state_next == S_HDR_LO) ||
                      (w_state_next == S_DATA)   || (w_state_next == S_CHECK);
      r_mem_we     <= w_we_next;
      r_mem_addr   <= w_addr_next;
      r_mem_wdata  <= w_wdata_next;
      r_cpu_reset  <= (w_state_next != S_DONE);
      r_done       <= (w_state_next == S_DONE);
      r_error      <= (w_state_next == S_ERROR);
    end
  end

  assign byte_ready   = r_byte_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_wl;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them whenever mem_we is seen.
module tb_inst_loader;

  localparam int AW = 8;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [AW:0] words_loaded;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [7:0]  nom[11] = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04,
                           8'h00, 8'h22, 8'h18, 8'h20, 8'h91};

  inst_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr", mem_addr, mon_exp[63:32]);
        check("write_data", mem_wdata, mon_exp[31:0]);
        $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      byte_valid = 1'b0;
    end
    @(negedge clock);
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: byte 0x%02h never accepted, byte_ready=%0b, expected 1", b, byte_ready);
    end
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_nominal(input int stall, input logic [7:0] chk);
    for (int i = 0; i < 10; i++) send_byte(nom[i], stall);
    send_byte(chk, stall);
  endtask

  task automatic push_nominal();
    exp_q.push_back({32'h0000_0000, 32'h8C01_0004});
    exp_q.push_back({32'h0000_0004, 32'h0022_1820});
  endtask

  task automatic settle_and_check(input string tag, input logic exp_done, input logic [31:0] exp_wl);
    int t;
    t = 0;
    while (!(done || error) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_settle: done=%0b error=%0b, expected one of them set", tag, done, error);
    end
    @(negedge clock);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), exp_wl);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    $display("%s: done=%0b error=%0b cpu_reset=%0b words_loaded=%0d", tag, done, error, cpu_reset, words_loaded);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0000_0000);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    logic [7:0] acc;
    logic [7:0] wb[4];

    reset = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;

    // Nominal frame, back-to-back bytes.
    push_nominal();
    pulse_start();
    send_nominal(0, 8'h91);
    settle_and_check("nominal", 1'b1, 32'd2);

    // Restart from DONE re-asserts cpu_reset on the very next cycle.
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_byte_ready", 32'(byte_ready), 32'd1);
    push_nominal();
    send_nominal(3, 8'h91);
    settle_and_check("stalled", 1'b1, 32'd2);

    // Bad checksum: writes still occur, load ends in ERROR.
    push_nominal();
    pulse_start();
    send_nominal(0, 8'h90);
    settle_and_check("badchk", 1'b0, 32'd2);
    push_nominal();
    pulse_start();
    send_nominal(1, 8'h91);
    settle_and_check("recover", 1'b1, 32'd2);

    // Oversize header: 0x0101 words exceeds 256.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clock);
    check("oversize_error", 32'(error), 32'd1);
    check("oversize_byte_ready", 32'(byte_ready), 32'd0);
    settle_and_check("oversize", 1'b0, 32'd0);

    // Exactly 256 words is the largest accepted image.
    pulse_start();
    acc = 8'h01;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      wb[0] = 8'(i);
      wb[1] = 8'hA5 ^ 8'(i);
      wb[2] = 8'h3C;
      wb[3] = 8'(i + 1);
      exp_q.push_back({32'(i * 4), wb[0], wb[1], wb[2], wb[3]});
      for (int k = 0; k < 4; k++) begin
        acc = acc ^ wb[k];
        send_byte(wb[k], 0);
      end
    end
    send_byte(acc, 0);
    settle_and_check("maxsize", 1'b1, 32'd256);

    // Empty image.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    settle_and_check("empty", 1'b1, 32'd0);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    settle_and_check("empty_badchk", 1'b0, 32'd0);

    // Reset mid-word: outputs clear without waiting for a clock edge.
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(nom[i], 0);
    @(negedge clock);
    check("midword_ready_before", 32'(byte_ready), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clock);
    reset = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check("nostart_byte_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    check("nostart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("nostart_done", 32'(done), 32'd0);
    check("nostart_pending_writes", 32'(exp_q.size()), 32'd0);

    push_nominal();
    pulse_start();
    send_nominal(0, 8'h91);
    settle_and_check("after_reset", 1'b1, 32'd2);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
